pll_phase_array_top: RTL and testbench
======================================

// Module: pll_phase_array_top
// PURPOSE
//   Drive signal generator for an 8x8 ultrasonic transducer array (acoustic levitation).
//   Produces 64 square waves wavR_C (R = row 0..7, C = column 0..7) at a common carrier
//   frequency (default 50 MHz / 1250 = 40 kHz).
//   Each wave is delayed by a per-element phase offset so that the emitted field is steered.
//   clk_out is the phase-0 reference carrier.
//   Purely counter-based: no vendor PLL primitive, fully synthesizable, one clock domain.
// PARAMETERS
//   PERIOD    1250  carrier period in clk cycles (>= 2)
//   HIGH      625   high time per period in clk cycles (1..PERIOD-1); default gives 50% duty
//   ROW_STEP  40    phase-offset increment per row, in clk cycles
//   COL_STEP  5     phase-offset increment per column, in clk cycles
//   CW        11    counter width; must satisfy 2**CW >= PERIOD
// PORTS
//   clk        in   1  system clock, 50 MHz nominal; all logic on the rising edge
//   rst_n      in   1  reset, synchronous, active-low
//   clk_out    out  1  reference carrier, phase offset 0
//   wav0_0 .. wav7_7
//              out  1  each; 64 separate scalar ports wavR_C, one per array element
//                      (R = row, C = column), phase-shifted carrier
// BEHAVIOUR
//   - Phase counter cnt[CW-1:0]:
//     - rst_n=0 at a rising edge: cnt <= 0.
//     - Otherwise: cnt <= (cnt == PERIOD-1) ? 0 : cnt + 1.
//   - Offsets are constants fixed at elaboration: OFF(R,C) = (R*ROW_STEP + C*COL_STEP) mod PERIOD.
//     With the defaults OFF ranges 0..315.
//   - Per-element phase: ph = (cnt >= OFF) ? cnt - OFF : cnt + PERIOD - OFF.
//     Always in 0..PERIOD-1; no wrap error.
//   - All outputs are registered with 1-cycle latency. At each rising edge with rst_n=1:
//     - wavR_C <= (ph(R,C) < HIGH), where ph is computed from the pre-edge cnt.
//     - clk_out <= (cnt < HIGH).
//   - Reset: every output (clk_out and all 64 waves) is 0 on the edge where rst_n=0 is sampled.
//     Outputs stay 0 while rst_n stays low.
//   - First edge after release: cnt = 0, so clk_out goes 1 and wav0_0 (OFF=0) goes 1.
//     An element with OFF = k > 0 first goes high on edge k+1 after release.
//   - Steady state per output: exactly HIGH cycles at 1 and PERIOD-HIGH cycles at 0.
//     Period is exactly PERIOD cycles, no jitter.
//   - wavR_C is identical to clk_out delayed by OFF(R,C) cycles (modulo PERIOD).
//   - Reset mid-operation: counter and outputs return to 0 at once; the full sequence restarts
//     from phase 0 after release, with no residual state.
//   - OFF = 0 elements (with defaults only wav0_0) are bit-identical to clk_out.
//   - Outputs are glitch-free: registered, single driver each, no combinational output path.
// TESTING
//   1. Reset: clk = 50 MHz (20 ns period), rst_n=0 until 100 ns.
//      -> all 65 outputs 0 through 100 ns.
//      -> first edge with rst_n=1 at 110 ns: clk_out=1 and wav0_0=1; every other wav still 0.
//   2. Carrier (defaults): clk_out period 25 us (1250 cycles), high 12.5 us.
//      -> falls at 12610 ns, rises again at 25110 ns; wav0_0 tracks clk_out exactly.
//   3. Column phase: wav0_1 rises at 210 ns (5 cycles after clk_out).
//      -> wav0_7 rises at 810 ns; wav1_0 rises at 910 ns (40 cycles).
//   4. Corner element: wav7_7 (OFF=315) rises at 6410 ns, falls at 18910 ns.
//      -> period 1250 cycles.
//   5. Reset mid-run: assert rst_n=0 for 3 cycles at ~40 us.
//      -> all outputs 0 on the next edge.
//      -> after release the timing of checks 1..4 repeats relative to the release edge.
//   6. Override PERIOD=10, HIGH=5, ROW_STEP=3, COL_STEP=4:
//      -> wav7_7 OFF = 49 mod 10 = 9; waveform = clk_out delayed 9 cycles.
//      -> every output 5 cycles high / 5 cycles low.

Source files
------------

// File: rtl/pll_phase_array_top.sv
// Counter-based phase-steered carrier generator for an 8x8 ultrasonic transducer array.
// One free-running phase counter; each element compares a constant-offset phase against HIGH.
module pll_phase_array_top #(
    parameter int PERIOD   = 1250,
    parameter int HIGH     = 625,
    parameter int ROW_STEP = 40,
    parameter int COL_STEP = 5,
    parameter int CW       = 11
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out,
    output logic wav0_0, wav0_1, wav0_2, wav0_3, wav0_4, wav0_5, wav0_6, wav0_7,
    output logic wav1_0, wav1_1, wav1_2, wav1_3, wav1_4, wav1_5, wav1_6, wav1_7,
    output logic wav2_0, wav2_1, wav2_2, wav2_3, wav2_4, wav2_5, wav2_6, wav2_7,
    output logic wav3_0, wav3_1, wav3_2, wav3_3, wav3_4, wav3_5, wav3_6, wav3_7,
    output logic wav4_0, wav4_1, wav4_2, wav4_3, wav4_4, wav4_5, wav4_6, wav4_7,
    output logic wav5_0, wav5_1, wav5_2, wav5_3, wav5_4, wav5_5, wav5_6, wav5_7,
    output logic wav6_0, wav6_1, wav6_2, wav6_3, wav6_4, wav6_5, wav6_6, wav6_7,
    output logic wav7_0, wav7_1, wav7_2, wav7_3, wav7_4, wav7_5, wav7_6, wav7_7
);

    localparam logic [CW-1:0] PERIOD_M1 = CW'(PERIOD - 1);
    localparam logic [CW-1:0] HIGH_C    = CW'(HIGH);
    localparam logic [CW:0]   PERIOD_X  = (CW+1)'(PERIOD);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          clk_out_reg;
    logic [63:0]   wav_reg;
    logic [63:0]   wav_next;

    always_comb begin
        cnt_next = (cnt_reg == PERIOD_M1) ? '0 : cnt_reg + 1'b1;
    end

    // Element index gi = row*8 + column; offsets are elaboration-time constants.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_elem
            localparam logic [CW-1:0] OFF_C =
                CW'((((gi / 8) * ROW_STEP) + ((gi % 8) * COL_STEP)) % PERIOD);
            logic [CW:0] ph;

            // Widened by one bit so cnt + PERIOD - OFF cannot overflow before the subtract.
            always_comb begin
                if (cnt_reg >= OFF_C)
                    ph = {1'b0, cnt_reg - OFF_C};
                else
                    ph = {1'b0, cnt_reg} + PERIOD_X - {1'b0, OFF_C};
            end

            assign wav_next[gi] = (ph < {1'b0, HIGH_C});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            wav_reg     <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            clk_out_reg <= (cnt_reg < HIGH_C);
            wav_reg     <= wav_next;
        end
    end

    assign clk_out = clk_out_reg;

    assign wav0_0 = wav_reg[0];   assign wav0_1 = wav_reg[1];
    assign wav0_2 = wav_reg[2];   assign wav0_3 = wav_reg[3];
    assign wav0_4 = wav_reg[4];   assign wav0_5 = wav_reg[5];
    assign wav0_6 = wav_reg[6];   assign wav0_7 = wav_reg[7];
    assign wav1_0 = wav_reg[8];   assign wav1_1 = wav_reg[9];
    assign wav1_2 = wav_reg[10];  assign wav1_3 = wav_reg[11];
    assign wav1_4 = wav_reg[12];  assign wav1_5 = wav_reg[13];
    assign wav1_6 = wav_reg[14];  assign wav1_7 = wav_reg[15];
    assign wav2_0 = wav_reg[16];  assign wav2_1 = wav_reg[17];
    assign wav2_2 = wav_reg[18];  assign wav2_3 = wav_reg[19];
    assign wav2_4 = wav_reg[20];  assign wav2_5 = wav_reg[21];
    assign wav2_6 = wav_reg[22];  assign wav2_7 = wav_reg[23];
    assign wav3_0 = wav_reg[24];  assign wav3_1 = wav_reg[25];
    assign wav3_2 = wav_reg[26];  assign wav3_3 = wav_reg[27];
    assign wav3_4 = wav_reg[28];  assign wav3_5 = wav_reg[29];
    assign wav3_6 = wav_reg[30];  assign wav3_7 = wav_reg[31];
    assign wav4_0 = wav_reg[32];  assign wav4_1 = wav_reg[33];
    assign wav4_2 = wav_reg[34];  assign wav4_3 = wav_reg[35];
    assign wav4_4 = wav_reg[36];  assign wav4_5 = wav_reg[37];
    assign wav4_6 = wav_reg[38];  assign wav4_7 = wav_reg[39];
    assign wav5_0 = wav_reg[40];  assign wav5_1 = wav_reg[41];
    assign wav5_2 = wav_reg[42];  assign wav5_3 = wav_reg[43];
    assign wav5_4 = wav_reg[44];  assign wav5_5 = wav_reg[45];
    assign wav5_6 = wav_reg[46];  assign wav5_7 = wav_reg[47];
    assign wav6_0 = wav_reg[48];  assign wav6_1 = wav_reg[49];
    assign wav6_2 = wav_reg[50];  assign wav6_3 = wav_reg[51];
    assign wav6_4 = wav_reg[52];  assign wav6_5 = wav_reg[53];
    assign wav6_6 = wav_reg[54];  assign wav6_7 = wav_reg[55];
    assign wav7_0 = wav_reg[56];  assign wav7_1 = wav_reg[57];
    assign wav7_2 = wav_reg[58];  assign wav7_3 = wav_reg[59];
    assign wav7_4 = wav_reg[60];  assign wav7_5 = wav_reg[61];
    assign wav7_6 = wav_reg[62];  assign wav7_7 = wav_reg[63];

endmodule

// File: tb/tb_pll_phase_array_top.sv
// Directed bench: default array (a) and a PERIOD=10 override (b) run side by side on one reset.
module tb_pll_phase_array_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_out_a, clk_out_b;
    logic [63:0] w_a, w_b;
    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    int          hi_clk, hi_77;
    logic [15:0] hist_b;

    always #10 clk = ~clk;

    pll_phase_array_top dut_a (
        .clk(clk), .rst_n(rst_n), .clk_out(clk_out_a),
        .wav0_0(w_a[0]),  .wav0_1(w_a[1]),  .wav0_2(w_a[2]),  .wav0_3(w_a[3]),  .wav0_4(w_a[4]),  .wav0_5(w_a[5]),  .wav0_6(w_a[6]),  .wav0_7(w_a[7]),
        .wav1_0(w_a[8]),  .wav1_1(w_a[9]),  .wav1_2(w_a[10]), .wav1_3(w_a[11]), .wav1_4(w_a[12]), .wav1_5(w_a[13]), .wav1_6(w_a[14]), .wav1_7(w_a[15]),
        .wav2_0(w_a[16]), .wav2_1(w_a[17]), .wav2_2(w_a[18]), .wav2_3(w_a[19]), .wav2_4(w_a[20]), .wav2_5(w_a[21]), .wav2_6(w_a[22]), .wav2_7(w_a[23]),
        .wav3_0(w_a[24]), .wav3_1(w_a[25]), .wav3_2(w_a[26]), .wav3_3(w_a[27]), .wav3_4(w_a[28]), .wav3_5(w_a[29]), .wav3_6(w_a[30]), .wav3_7(w_a[31]),
        .wav4_0(w_a[32]), .wav4_1(w_a[33]), .wav4_2(w_a[34]), .wav4_3(w_a[35]), .wav4_4(w_a[36]), .wav4_5(w_a[37]), .wav4_6(w_a[38]), .wav4_7(w_a[39]),
        .wav5_0(w_a[40]), .wav5_1(w_a[41]), .wav5_2(w_a[42]), .wav5_3(w_a[43]), .wav5_4(w_a[44]), .wav5_5(w_a[45]), .wav5_6(w_a[46]), .wav5_7(w_a[47]),
        .wav6_0(w_a[48]), .wav6_1(w_a[49]), .wav6_2(w_a[50]), .wav6_3(w_a[51]), .wav6_4(w_a[52]), .wav6_5(w_a[53]), .wav6_6(w_a[54]), .wav6_7(w_a[55]),
        .wav7_0(w_a[56]), .wav7_1(w_a[57]), .wav7_2(w_a[58]), .wav7_3(w_a[59]), .wav7_4(w_a[60]), .wav7_5(w_a[61]), .wav7_6(w_a[62]), .wav7_7(w_a[63])
    );

    pll_phase_array_top #(.PERIOD(10), .HIGH(5), .ROW_STEP(3), .COL_STEP(4), .CW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_out(clk_out_b),
        .wav0_0(w_b[0]),  .wav0_1(w_b[1]),  .wav0_2(w_b[2]),  .wav0_3(w_b[3]),  .wav0_4(w_b[4]),  .wav0_5(w_b[5]),  .wav0_6(w_b[6]),  .wav0_7(w_b[7]),
        .wav1_0(w_b[8]),  .wav1_1(w_b[9]),  .wav1_2(w_b[10]), .wav1_3(w_b[11]), .wav1_4(w_b[12]), .wav1_5(w_b[13]), .wav1_6(w_b[14]), .wav1_7(w_b[15]),
        .wav2_0(w_b[16]), .wav2_1(w_b[17]), .wav2_2(w_b[18]), .wav2_3(w_b[19]), .wav2_4(w_b[20]), .wav2_5(w_b[21]), .wav2_6(w_b[22]), .wav2_7(w_b[23]),
        .wav3_0(w_b[24]), .wav3_1(w_b[25]), .wav3_2(w_b[26]), .wav3_3(w_b[27]), .wav3_4(w_b[28]), .wav3_5(w_b[29]), .wav3_6(w_b[30]), .wav3_7(w_b[31]),
        .wav4_0(w_b[32]), .wav4_1(w_b[33]), .wav4_2(w_b[34]), .wav4_3(w_b[35]), .wav4_4(w_b[36]), .wav4_5(w_b[37]), .wav4_6(w_b[38]), .wav4_7(w_b[39]),
        .wav5_0(w_b[40]), .wav5_1(w_b[41]), .wav5_2(w_b[42]), .wav5_3(w_b[43]), .wav5_4(w_b[44]), .wav5_5(w_b[45]), .wav5_6(w_b[46]), .wav5_7(w_b[47]),
        .wav6_0(w_b[48]), .wav6_1(w_b[49]), .wav6_2(w_b[50]), .wav6_3(w_b[51]), .wav6_4(w_b[52]), .wav6_5(w_b[53]), .wav6_6(w_b[54]), .wav6_7(w_b[55]),
        .wav7_0(w_b[56]), .wav7_1(w_b[57]), .wav7_2(w_b[58]), .wav7_3(w_b[59]), .wav7_4(w_b[60]), .wav7_5(w_b[61]), .wav7_6(w_b[62]), .wav7_7(w_b[63])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s (edge %0d): observed %h expected %h", tag, k, obs, expv);
        end
    endtask

    // Expected state of all 64 elements after release edge kk (cnt before that edge = kk-1).
    function automatic logic [63:0] exp_vec(input int kk, input int p, input int h,
                                            input int rs, input int cs);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int off, ph;
                off = (r * rs + c * cs) % p;
                ph  = (((kk - 1 - off) % p) + p) % p;
                v[r*8+c] = (ph < h);
            end
        end
        return v;
    endfunction

    function automatic logic exp_clk(input int kk, input int p, input int h);
        return (((kk - 1) % p) < h);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Runs n edges after a release, checking both arrays each edge plus directed points.
    task automatic run_phase(input int n);
        hi_clk = 0;
        hi_77  = 0;
        hist_b = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("vec_a", w_a, exp_vec(k, 1250, 625, 40, 5));
            check("clk_out_a", {63'd0, clk_out_a}, {63'd0, exp_clk(k, 1250, 625)});
            check("vec_b", w_b, exp_vec(k, 10, 5, 3, 4));
            check("clk_out_b", {63'd0, clk_out_b}, {63'd0, exp_clk(k, 10, 5)});
            hist_b = {hist_b[14:0], clk_out_b};
            if (k > 9)
                check("b_wav7_7_is_clk_out_dly9", {63'd0, w_b[63]}, {63'd0, hist_b[9]});
            if (k <= 1250) begin
                hi_clk += int'(clk_out_a);
                hi_77  += int'(w_a[63]);
            end
            case (k)
                1: begin
                    check("first_clk_out", {63'd0, clk_out_a}, 64'd1);
                    check("first_wav0_0", {63'd0, w_a[0]}, 64'd1);
                    check("first_others", {w_a[63:1], 1'b0}, 64'd0);
                end
                5:    check("wav0_1_before_rise", {63'd0, w_a[1]}, 64'd0);
                6:    check("wav0_1_rise_210ns", {63'd0, w_a[1]}, 64'd1);
                9:    check("b_wav7_7_before_rise", {63'd0, w_b[63]}, 64'd0);
                10:   check("b_wav7_7_rise", {63'd0, w_b[63]}, 64'd1);
                15:   check("b_wav7_7_fall", {63'd0, w_b[63]}, 64'd0);
                35:   check("wav0_7_before_rise", {63'd0, w_a[7]}, 64'd0);
                36:   check("wav0_7_rise_810ns", {63'd0, w_a[7]}, 64'd1);
                40:   check("wav1_0_before_rise", {63'd0, w_a[8]}, 64'd0);
                41:   check("wav1_0_rise_910ns", {63'd0, w_a[8]}, 64'd1);
                315:  check("wav7_7_before_rise", {63'd0, w_a[63]}, 64'd0);
                316:  check("wav7_7_rise_6410ns", {63'd0, w_a[63]}, 64'd1);
                625:  check("clk_out_last_high", {63'd0, clk_out_a}, 64'd1);
                626: begin
                    check("clk_out_fall_12610ns", {63'd0, clk_out_a}, 64'd0);
                    check("wav0_0_tracks_fall", {63'd0, w_a[0]}, 64'd0);
                end
                940:  check("wav7_7_last_high", {63'd0, w_a[63]}, 64'd1);
                941:  check("wav7_7_fall_18910ns", {63'd0, w_a[63]}, 64'd0);
                1250: check("clk_out_low_before_rerise", {63'd0, clk_out_a}, 64'd0);
                1251: begin
                    check("clk_out_rerise_25110ns", {63'd0, clk_out_a}, 64'd1);
                    check("wav0_0_tracks_rise", {63'd0, w_a[0]}, 64'd1);
                end
                1566: check("wav7_7_second_rise", {63'd0, w_a[63]}, 64'd1);
                default: ;
            endcase
        end
        if (n >= 1250) begin
            check("clk_out_high_count", 64'(hi_clk), 64'd625);
            check("wav7_7_high_count", 64'(hi_77), 64'd625);
        end
    endtask

    initial begin
        // Reset held low through 100 ns: edges at 10..90 ns.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_clk_out_a", {63'd0, clk_out_a}, 64'd0);
            check("reset_vec_a", w_a, 64'd0);
            check("reset_vec_b", {w_b[63:1], clk_out_b}, 64'd0);
        end
        rst_n = 1'b1;
        k = 0;
        run_phase(1570);

        // Free-run to about 40 us, then pulse reset for 3 cycles.
        while (k < 1995) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrun_reset_clk_out_a", {63'd0, clk_out_a}, 64'd0);
            check("midrun_reset_vec_a", w_a, 64'd0);
            check("midrun_reset_vec_b", {w_b[63:1], clk_out_b}, 64'd0);
        end
        rst_n = 1'b1;
        k = 0;
        run_phase(1300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
